muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit. It sits directly downstream of the register file read ports: it consumes the two source-operand values and a destination index. When finished, it produces a write-back value, index and write enable that feed the register file write port. It stalls the core through `busy` while computing.

---
 rtl/muldiv_unit.sv | 184 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring shift-subtract step per clock.
// Optional MULDIV_FAST_MUL_EN: multiplies finish in a single cycle using a wide multiplier.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            wb_we
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opd_q, opd_d;
  logic              sign_q, sign_d;
  logic [2:0]        f3_q, f3_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand decode at the accept edge
  logic            is_div;
  logic            sgn_a_en, sgn_b_en;
  logic            neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_word;

  always_comb begin
    is_div   = funct3[2];
    sgn_a_en = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
    sgn_b_en = is_div ? ~funct3[0] : ~funct3[1];
    neg_a    = sgn_a_en & rs1_val[XLEN-1];
    neg_b    = sgn_b_en & rs2_val[XLEN-1];
    mag_a    = neg_a ? -rs1_val : rs1_val;
    mag_b    = neg_b ? -rs2_val : rs2_val;
    div_zero = is_div & (rs2_val == '0);
    div_ovf  = is_div & ~funct3[0] & (rs1_val == INT_MIN) & (rs2_val == '1);
    if (div_zero) special_word = funct3[1] ? rs1_val : '1;
    else          special_word = funct3[1] ? '0 : INT_MIN;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;

  always_comb begin
    fast_a    = {{XLEN{neg_a}}, rs1_val};
    fast_b    = {{XLEN{neg_b}}, rs2_val};
    fast_prod = fast_a * fast_b;
  end
`endif

  // One iteration step: acc holds {product} for multiply, {remainder, quotient} for divide
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_sub;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] step_next;
  logic [2*XLEN-1:0] mul_fix;
  logic [XLEN-1:0]   mul_word;
  logic [XLEN-1:0]   div_raw;
  logic [XLEN-1:0]   div_word;
  logic [XLEN-1:0]   fin_word;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};

    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opd_q};
    // Remainder stays below the divisor, so the low XLEN bits of the difference are exact
    div_sub   = div_shift[XLEN-1:0] - opd_q;
    div_next  = {(div_ge ? div_sub : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};

    step_next = f3_q[2] ? div_next : mul_next;

    mul_fix   = sign_q ? -mul_next : mul_next;
    mul_word  = (f3_q[1:0] == 2'b00) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
    div_raw   = f3_q[1] ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
    div_word  = sign_q ? -div_raw : div_raw;
    fin_word  = f3_q[2] ? div_word : mul_word;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opd_d    = opd_q;
    sign_d   = sign_q;
    f3_d     = f3_q;
    rd_d     = rd_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          f3_d   = funct3;
          rd_d   = rd_in;
          cnt_d  = '0;
          sign_d = (funct3[2] & funct3[1]) ? neg_a : (neg_a ^ neg_b);
          if (is_div) begin
            opd_d = mag_b;
            acc_d = {{XLEN{1'b0}}, mag_a};
          end else begin
            opd_d = mag_a;
            acc_d = {{XLEN{1'b0}}, mag_b};
          end
          if (div_zero || div_ovf) begin
            result_d = special_word;
            state_d  = S_DONE;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!is_div) begin
            result_d = (funct3[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
            state_d  = S_DONE;
          end
`endif
          else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = step_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          result_d = fin_word;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opd_q    <= '0;
      sign_q   <= 1'b0;
      f3_q     <= '0;
      rd_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opd_q    <= opd_d;
      sign_q   <= sign_d;
      f3_q     <= f3_d;
      rd_q     <= rd_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    busy   = (state_q == S_CALC) || (state_q == S_DONE);
    done   = (state_q == S_DONE);
    result = result_q;
    rd_out = rd_q;
    wb_we  = done && (rd_q != 5'd0);
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit; latency is counted in clock edges after the accept edge.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 32;
`endif
  localparam int DIV_LAT  = 32;
  // Special-case divides go IDLE->DONE on the accept edge itself
  localparam int SPEC_LAT = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        wb_we;

  int total  = 0;
  int passed = 0;
  int wb_seen = 0;
  logic mon_en = 1'b0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .funct3  (funct3),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .rd_in   (rd_in),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .rd_out  (rd_out),
    .wb_we   (wb_we)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mon_en && wb_we) wb_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input int exp_lat);
    int lat;
    int busy_n;
    int we_n;
    @(negedge clk);
    start = 1'b1; funct3 = f; rs1_val = a; rs2_val = b; rd_in = rd;
    @(posedge clk); #1;
    start = 1'b0; rs1_val = $urandom; rs2_val = $urandom; rd_in = 5'($urandom);
    lat = 0;
    busy_n = busy ? 1 : 0;
    we_n = wb_we ? 1 : 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_n++;
      if (wb_we) we_n++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, result, exp);
    check({tag, " rd_out"}, {27'd0, rd_out}, {27'd0, rd});
    check({tag, " wb_we pulses"}, we_n, (rd != 5'd0) ? 1 : 0);
    check({tag, " busy cycles"}, busy_n, exp_lat + 1);
    @(posedge clk); #1;
    check({tag, " idle busy/done"}, {30'd0, busy, done}, 32'd0);
    check({tag, " result held"}, result, exp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; funct3 = '0; rs1_val = '0; rs2_val = '0; rd_in = '0;
    #3;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset wb_we", {31'd0, wb_we}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset rd_out", {27'd0, rd_out}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    do_op("MUL 7*6",        3'b000, 32'd7,        32'd6,        5'd5,  32'd42,       MUL_LAT);
    do_op("MUL -3*5",       3'b000, 32'hFFFFFFFD, 32'd5,        5'd7,  32'hFFFFFFF1, MUL_LAT);
    do_op("MULH -1*2",      3'b001, 32'hFFFFFFFF, 32'd2,        5'd6,  32'hFFFFFFFF, MUL_LAT);
    do_op("MULHU ffff*2",   3'b011, 32'hFFFFFFFF, 32'd2,        5'd6,  32'h00000001, MUL_LAT);
    do_op("MULHSU -1*ffff", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, MUL_LAT);
    do_op("DIV -7/2",       3'b100, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD, DIV_LAT);
    do_op("REM -7/2",       3'b110, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, DIV_LAT);
    do_op("DIV 20/-3",      3'b100, 32'd20,       32'hFFFFFFFD, 5'd11, 32'hFFFFFFFA, DIV_LAT);
    do_op("REM 20/-3",      3'b110, 32'd20,       32'hFFFFFFFD, 5'd11, 32'd2,        DIV_LAT);
    do_op("DIVU 100/7",     3'b101, 32'd100,      32'd7,        5'd12, 32'd14,       DIV_LAT);
    do_op("REMU 100/7",     3'b111, 32'd100,      32'd7,        5'd12, 32'd2,        DIV_LAT);
    do_op("DIVU 123/0",     3'b101, 32'd123,      32'd0,        5'd13, 32'hFFFFFFFF, SPEC_LAT);
    do_op("REM 123/0",      3'b110, 32'd123,      32'd0,        5'd13, 32'd123,      SPEC_LAT);
    do_op("DIV ovf",        3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, SPEC_LAT);
    do_op("REM ovf",        3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0,        SPEC_LAT);

    // Abort: DIVU in flight, ignored second start at edge 10, reset around edge 20
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; rs1_val = 32'd100; rs2_val = 32'd7; rd_in = 5'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wb_seen = 0;
    mon_en = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      @(posedge clk); #1;
      if (i == 9) begin
        start = 1'b1; funct3 = 3'b000; rs1_val = 32'd3; rs2_val = 32'd3; rd_in = 5'd9;
      end
      if (i == 10) begin
        start = 1'b0;
        check("abort busy after 2nd start", {31'd0, busy}, 32'd1);
        check("abort rd_out kept", {27'd0, rd_out}, 32'd3);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort rst busy", {31'd0, busy}, 32'd0);
    check("abort rst done", {31'd0, done}, 32'd0);
    check("abort rst result", result, 32'd0);
    check("abort rst rd_out", {27'd0, rd_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("abort no wb_we", wb_seen, 32'd0);
    check("abort idle busy", {31'd0, busy}, 32'd0);
    mon_en = 1'b0;

    do_op("MUL 3*3 after rst", 3'b000, 32'd3, 32'd3, 5'd1, 32'd9, MUL_LAT);
    do_op("MUL rd0 2*3",       3'b000, 32'd2, 32'd3, 5'd0, 32'd6, MUL_LAT);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
